hart_irq_ctrl: RTL and testbench

Per-hart machine-level interrupt front end, downstream of the CLINT and PLIC. It registers the hart's pending sources (MSIP and MTIP from the CLINT, MEIP from the PLIC) and applies the mie enables and the mstatus.MIE global enable. It then prioritises the enabled sources and presents one interrupt request with a stable mcause to the core over a req/ack handshake. It also generates the WFI wake-up.

---
 rtl/hart_irq_ctrl.sv | 106 ++++++++++
 tb/tb_hart_irq_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hart_irq_ctrl.sv
// Per-hart machine interrupt front end: registers MSIP/MTIP/MEIP, masks and prioritises them,
// and drives a req/ack interrupt request plus WFI wake. HART_IRQ_SYNC_EN adds a meip synchronizer.
module hart_irq_ctrl #(
  parameter int DWIDTH      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msip,
  input  logic              mtip,
  input  logic              meip,
  input  logic              mstatus_mie,
  input  logic [2:0]        csr_mie,
  input  logic              irq_ack,
  input  logic              wfi,
  output logic [2:0]        mip,
  output logic              irq_req,
  output logic [DWIDTH-1:0] irq_cause,
  output logic              wake
);

  localparam logic [DWIDTH-1:0] IRQ_FLAG  = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [DWIDTH-1:0] CAUSE_MSI = IRQ_FLAG | DWIDTH'(3);
  localparam logic [DWIDTH-1:0] CAUSE_MTI = IRQ_FLAG | DWIDTH'(7);
  localparam logic [DWIDTH-1:0] CAUSE_MEI = IRQ_FLAG | DWIDTH'(11);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state, state_n;
  logic              meip_s;
  logic [2:0]        en;
  logic              take;
  logic              req_n;
  logic [DWIDTH-1:0] cause_sel, cause_n;

  // Marker for an illegal synchronizer depth; a depth below 2 is not a synchronizer.
  if (SYNC_STAGES < 2) begin : g_sync_stages_illegal
  end

`ifdef HART_IRQ_SYNC_EN
  logic [SYNC_STAGES-1:0] meip_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) meip_sync <= '0;
    else     meip_sync <= {meip_sync[SYNC_STAGES-2:0], meip};
  end

  assign meip_s = meip_sync[SYNC_STAGES-1];
`else
  assign meip_s = meip;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mip  <= '0;
      wake <= 1'b0;
    end else begin
      mip  <= {meip_s, mtip, msip};
      // WFI wakes on any enabled pending source regardless of mstatus.MIE
      wake <= wfi && (|en);
    end
  end

  assign en   = mip & csr_mie;
  assign take = mstatus_mie && (|en);

  always_comb begin
    cause_sel = CAUSE_MTI;
    if (en[2])      cause_sel = CAUSE_MEI;
    else if (en[0]) cause_sel = CAUSE_MSI;
  end

  always_comb begin
    state_n = state;
    req_n   = 1'b0;
    cause_n = irq_cause;
    case (state)
      IDLE: if (take) begin
        state_n = REQ;
        req_n   = 1'b1;
        cause_n = cause_sel;
      end
      // cause stays frozen for the life of the request; ack beats withdrawal
      REQ: begin
        if (irq_ack)    state_n = HOLD;
        else if (!take) state_n = IDLE;
        else            req_n   = 1'b1;
      end
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      irq_req   <= 1'b0;
      irq_cause <= '0;
    end else begin
      state     <= state_n;
      irq_req   <= req_n;
      irq_cause <= cause_n;
    end
  end

endmodule

// File: tb/tb_hart_irq_ctrl.sv
// Directed bench for hart_irq_ctrl: expectations are queued as stimulus is driven and
// popped when outputs are sampled 1ns after each rising edge.
module tb_hart_irq_ctrl;
  localparam int DWIDTH      = 32;
  localparam int SYNC_STAGES = 2;
`ifdef HART_IRQ_SYNC_EN
  localparam int MEIP_LAT = SYNC_STAGES + 1;
`else
  localparam int MEIP_LAT = 1;
`endif
  localparam logic [31:0] C_MSI = 32'h8000_0003;
  localparam logic [31:0] C_MTI = 32'h8000_0007;
  localparam logic [31:0] C_MEI = 32'h8000_000B;

  logic              clk = 1'b0, rst = 1'b1;
  logic              msip = 0, mtip = 0, meip = 0, mstatus_mie = 0, irq_ack = 0, wfi = 0;
  logic [2:0]        csr_mie = '0;
  logic [2:0]        mip;
  logic              irq_req, wake;
  logic [DWIDTH-1:0] irq_cause;

  hart_irq_ctrl #(.DWIDTH(DWIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .msip(msip), .mtip(mtip), .meip(meip),
    .mstatus_mie(mstatus_mie), .csr_mie(csr_mie), .irq_ack(irq_ack), .wfi(wfi),
    .mip(mip), .irq_req(irq_req), .irq_cause(irq_cause), .wake(wake)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    push("rst_mip", 0); push("rst_req", 0); push("rst_cause", 0); push("rst_wake", 0);
    tick(); tick();
    chk(mip); chk(irq_req); chk(irq_cause); chk(wake);
    rst = 1'b0;
    tick();

    // same-domain request, ack, HOLD, re-request
    csr_mie = 3'b001; mstatus_mie = 1; msip = 1;
    push("t1_mip", 3'b001); push("t1_req_early", 0);
    tick(); chk(mip); chk(irq_req);
    push("t1_req", 1); push("t1_cause", C_MSI);
    tick(); chk(irq_req); chk(irq_cause);
    irq_ack = 1;
    push("t1_ack_req", 0);
    tick(); irq_ack = 0; chk(irq_req);
    push("t1_rereq", 1); push("t1_rereq_cause", C_MSI);
    tick(); tick(); chk(irq_req); chk(irq_cause);
    msip = 0;
    push("t1_drop_req", 0);
    tick(); tick(); chk(irq_req);
    tick();

    // priority: everything pending, then global enable
    mstatus_mie = 0; csr_mie = 3'b111; msip = 1; mtip = 1; meip = 1;
    push("t2_mip", 3'b111); push("t2_req_off", 0);
    repeat (MEIP_LAT + 1) tick();
    chk(mip); chk(irq_req);
    mstatus_mie = 1;
    push("t2_req", 1); push("t2_cause", C_MEI);
    tick(); chk(irq_req); chk(irq_cause);
    meip = 0;
    push("t2_frozen_req", 1); push("t2_frozen_cause", C_MEI); push("t2_mip_drop", 3'b011);
    repeat (MEIP_LAT + 2) tick();
    chk(irq_req); chk(irq_cause); chk(mip);
    irq_ack = 1;
    push("t2_ack_req", 0);
    tick(); irq_ack = 0; chk(irq_req);
    push("t2_reeval_cause", C_MSI);
    tick(); tick(); chk(irq_cause);
    msip = 0; mtip = 0; mstatus_mie = 0;
    push("t2_off_req", 0);
    tick(); chk(irq_req);
    tick(); tick();

    // WFI wake ignores mstatus.MIE
    csr_mie = 3'b010; mtip = 1; wfi = 1;
    push("t3_wake_early", 0); push("t3_req_a", 0);
    tick(); chk(wake); chk(irq_req);
    push("t3_wake", 1); push("t3_req_b", 0);
    tick(); chk(wake); chk(irq_req);
    mstatus_mie = 1;
    push("t3_req", 1); push("t3_cause", C_MTI);
    tick(); chk(irq_req); chk(irq_cause);
    wfi = 0;
    push("t3_wake_off", 0);
    tick(); chk(wake);

    // withdrawal without ack
    mtip = 0;
    push("t4_req_k", 1); push("t4_mip_k", 0);
    tick(); chk(irq_req); chk(mip);
    push("t4_req_k1", 0);
    tick(); chk(irq_req);
    push("t4_req_k2", 0);
    tick(); chk(irq_req);

    // async reset mid-request
    mtip = 1; wfi = 1;
    push("t5_req_pre", 1);
    tick(); tick(); chk(irq_req);
    #2 rst = 1'b1;
    #1;
    push("t5_req", 0); push("t5_cause", 0); push("t5_mip", 0); push("t5_wake", 0);
    chk(irq_req); chk(irq_cause); chk(mip); chk(wake);
    mtip = 0; wfi = 0; mstatus_mie = 1; csr_mie = 3'b100;
    tick(); rst = 1'b0;
    tick();

    // meip latency (synchronizer depth dependent)
    meip = 1;
    for (int i = 1; i <= MEIP_LAT + 1; i++) begin
      push($sformatf("t6_mip2_%0d", i), (i >= MEIP_LAT) ? 1 : 0);
      push($sformatf("t6_req_%0d", i), (i >= MEIP_LAT + 1) ? 1 : 0);
      tick();
      chk(mip[2]); chk(irq_req);
    end
    push("t6_cause", C_MEI);
    chk(irq_cause);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
